// File: rtl/id_decode_stage.sv
// RV32I decode stage: registers one fetched instruction per cycle and decodes
// register addresses, immediate and control bits, with a one-cycle load-use bubble.
module id_decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [XLEN-1:0]   Instr_in,
  input  logic [XLEN-1:0]   Pc_in,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic              Flush,
  input  logic              Out_ready,
  output logic              Out_valid,
  output logic [XLEN-1:0]   Out_pc,
  output logic [REG_AW-1:0] A1,
  output logic [REG_AW-1:0] A2,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   Imm,
  output logic [6:0]        Opcode,
  output logic [2:0]        Funct3,
  output logic              Funct7b5,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Illegal,
  output logic              Hazard
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]        op;
  logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;
  logic              uses_rs1, uses_rs2, writes_rd;
  logic              mem_read_d, mem_write_d, illegal_d, reg_write_d;
  logic [XLEN-1:0]   imm_d;
  logic [REG_AW-1:0] a1_d, a2_d, a3_d;

  assign op    = Instr_in[6:0];
  assign rs1_f = Instr_in[19:15];
  assign rs2_f = Instr_in[24:20];
  assign rd_f  = Instr_in[11:7];

  always_comb begin
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    writes_rd   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    illegal_d   = 1'b0;
    imm_d       = '0;
    unique case (op)
      OP_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IALU: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm_d     = XLEN'($signed(Instr_in[31:20]));
      end
      OP_LOAD: begin
        uses_rs1   = 1'b1;
        writes_rd  = 1'b1;
        mem_read_d = 1'b1;
        imm_d      = XLEN'($signed(Instr_in[31:20]));
      end
      OP_STORE: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        mem_write_d = 1'b1;
        imm_d       = XLEN'($signed({Instr_in[31:25], Instr_in[11:7]}));
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_d    = XLEN'($signed({Instr_in[31], Instr_in[7], Instr_in[30:25],
                                  Instr_in[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        writes_rd = 1'b1;
        imm_d     = XLEN'($signed({Instr_in[31:12], 12'b0}));
      end
      OP_JAL: begin
        writes_rd = 1'b1;
        imm_d     = XLEN'($signed({Instr_in[31], Instr_in[19:12], Instr_in[20],
                                   Instr_in[30:21], 1'b0}));
      end
      OP_JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm_d     = XLEN'($signed(Instr_in[31:20]));
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign reg_write_d = writes_rd & (rd_f != '0);
  assign a1_d        = uses_rs1 ? rs1_f : '0;
  assign a2_d        = uses_rs2 ? rs2_f : '0;
  assign a3_d        = reg_write_d ? rd_f : '0;

  // Compare the registered load's rd against the raw source fields of the incoming instruction
  assign Hazard = In_valid & Out_valid & MemRead & (A3 != '0) &
                  (((A3 == rs1_f) & uses_rs1) | ((A3 == rs2_f) & uses_rs2));

  assign In_ready = ~Flush & ~Hazard & (~Out_valid | Out_ready);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_valid <= 1'b0;
      Out_pc    <= '0;
      A1        <= '0;
      A2        <= '0;
      A3        <= '0;
      Imm       <= '0;
      Opcode    <= '0;
      Funct3    <= '0;
      Funct7b5  <= 1'b0;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Illegal   <= 1'b0;
    end else if (Flush) begin
      Out_valid <= 1'b0;
    end else if (Out_valid && !Out_ready) begin
      Out_valid <= Out_valid;
    end else if (Hazard) begin
      Out_valid <= 1'b0;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Illegal   <= 1'b0;
    end else if (In_valid && In_ready) begin
      Out_valid <= 1'b1;
      Out_pc    <= Pc_in;
      A1        <= a1_d;
      A2        <= a2_d;
      A3        <= a3_d;
      Imm       <= imm_d;
      Opcode    <= op;
      Funct3    <= Instr_in[14:12];
      Funct7b5  <= Instr_in[30];
      RegWrite  <= reg_write_d;
      MemRead   <= mem_read_d;
      MemWrite  <= mem_write_d;
      Illegal   <= illegal_d;
    end else begin
      Out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed self-checking bench for id_decode_stage with hand-decoded RV32I vectors.
module tb_id_decode_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Instr_in, Pc_in;
  logic        In_valid, In_ready, Flush, Out_ready, Out_valid;
  logic [31:0] Out_pc, Imm;
  logic [4:0]  A1, A2, A3;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic        Funct7b5, RegWrite, MemRead, MemWrite, Illegal, Hazard;

  int unsigned checks = 0;
  int unsigned errors = 0;

  id_decode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr_in(Instr_in), .Pc_in(Pc_in),
    .In_valid(In_valid), .In_ready(In_ready), .Flush(Flush), .Out_ready(Out_ready),
    .Out_valid(Out_valid), .Out_pc(Out_pc), .A1(A1), .A2(A2), .A3(A3), .Imm(Imm),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Illegal(Illegal), .Hazard(Hazard)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    Instr_in = instr;
    Pc_in    = pc;
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; Instr_in = '0; Pc_in = '0; In_valid = 1'b0;
    Flush = 1'b0; Out_ready = 1'b0;
    #2;
    check("rst_valid", 32'(Out_valid), 32'd0);
    check("rst_a3", 32'(A3), 32'd0);
    check("rst_imm", Imm, 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    step(); step();
    Rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(In_ready), 32'd1);

    // addi x1,x0,5
    In_valid = 1'b1; Out_ready = 1'b1;
    present(32'h00500093, 32'h0000_0000);
    step();
    check("addi_valid", 32'(Out_valid), 32'd1);
    check("addi_a1", 32'(A1), 32'd0);
    check("addi_a2", 32'(A2), 32'd0);
    check("addi_a3", 32'(A3), 32'd1);
    check("addi_imm", Imm, 32'd5);
    check("addi_regwrite", 32'(RegWrite), 32'd1);

    // lw x2,0(x1)
    present(32'h0000A103, 32'h0000_0004);
    step();
    check("lw_memread", 32'(MemRead), 32'd1);
    check("lw_a1", 32'(A1), 32'd1);
    check("lw_a3", 32'(A3), 32'd2);
    check("lw_pc", Out_pc, 32'h4);
    present(32'h00208063, 32'h0000_0008);   // beq x1,x2: rs2 collides
    check("haz_rs2", 32'(Hazard), 32'd1);
    present(32'h123450B7, 32'h0000_0008);   // lui x1: no sources
    check("haz_lui", 32'(Hazard), 32'd0);
    check("haz_lui_ready", 32'(In_ready), 32'd1);
    present(32'h001101B3, 32'h0000_0008);   // add x3,x2,x1
    check("haz_add", 32'(Hazard), 32'd1);
    check("haz_in_ready", 32'(In_ready), 32'd0);
    step();
    check("bubble_valid", 32'(Out_valid), 32'd0);
    check("bubble_hazard", 32'(Hazard), 32'd0);
    check("bubble_in_ready", 32'(In_ready), 32'd1);
    step();
    check("add_valid", 32'(Out_valid), 32'd1);
    check("add_a1", 32'(A1), 32'd2);
    check("add_a2", 32'(A2), 32'd1);
    check("add_a3", 32'(A3), 32'd3);
    check("add_pc", Out_pc, 32'h8);

    // sw x3,8(x2)
    present(32'h00312423, 32'h0000_000C);
    step();
    check("sw_a1", 32'(A1), 32'd2);
    check("sw_a2", 32'(A2), 32'd3);
    check("sw_a3", 32'(A3), 32'd0);
    check("sw_imm", Imm, 32'd8);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_regwrite", 32'(RegWrite), 32'd0);

    // beq x1,x2,-4
    present(32'hFE208EE3, 32'h0000_0010);
    step();
    check("beq_imm", Imm, 32'hFFFF_FFFC);
    check("beq_a1", 32'(A1), 32'd1);
    check("beq_a2", 32'(A2), 32'd2);
    check("beq_a3", 32'(A3), 32'd0);

    present(32'h123450B7, 32'h0000_0014);   // lui x1,0x12345
    step();
    check("lui_imm", Imm, 32'h1234_5000);
    check("lui_a1", 32'(A1), 32'd0);
    check("lui_a3", 32'(A3), 32'd1);

    present(32'h008000EF, 32'h0000_0018);   // jal x1,8
    step();
    check("jal_imm", Imm, 32'd8);
    check("jal_regwrite", 32'(RegWrite), 32'd1);

    present(32'h00100013, 32'h0000_001C);   // addi x0,x0,1
    step();
    check("x0_regwrite", 32'(RegWrite), 32'd0);
    check("x0_a3", 32'(A3), 32'd0);

    // Downstream stall: addi x5,x6,-1 held for three cycles
    present(32'hFFF30293, 32'h0000_0040);
    step();
    check("neg_imm", Imm, 32'hFFFF_FFFF);
    check("neg_a1", 32'(A1), 32'd6);
    Out_ready = 1'b0;
    present(32'h123450B7, 32'h0000_0044);
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", 32'(In_ready), 32'd0);
      step();
      check("hold_valid", 32'(Out_valid), 32'd1);
      check("hold_pc", Out_pc, 32'h40);
      check("hold_a3", 32'(A3), 32'd5);
      check("hold_imm", Imm, 32'hFFFF_FFFF);
    end
    Out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(In_ready), 32'd1);
    step();
    check("release_pc", Out_pc, 32'h44);
    check("release_a3", 32'(A3), 32'd1);

    // Flush with valid output and valid input
    Flush = 1'b1;
    present(32'h1234567F, 32'h0000_0048);
    check("flush_in_ready", 32'(In_ready), 32'd0);
    step();
    check("flush_valid", 32'(Out_valid), 32'd0);
    Flush = 1'b0;
    step();
    check("ill_valid", 32'(Out_valid), 32'd1);
    check("ill_flag", 32'(Illegal), 32'd1);
    check("ill_ctrl", {29'd0, RegWrite, MemRead, MemWrite}, 32'd0);
    check("ill_addrs", {17'd0, A1, A2, A3}, 32'd0);
    check("ill_imm", Imm, 32'd0);
    check("ill_opcode", 32'(Opcode), 32'h7F);

    // Asynchronous reset in the middle of a hold
    present(32'h00500093, 32'h0000_004C);
    step();
    Out_ready = 1'b0;
    step();
    check("prerst_valid", 32'(Out_valid), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_valid", 32'(Out_valid), 32'd0);
    check("async_a3", 32'(A3), 32'd0);
    check("async_imm", Imm, 32'd0);
    check("async_pc", Out_pc, 32'd0);
    check("async_regwrite", 32'(RegWrite), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Instruction decode stage sitting between fetch and execute. It registers one fetched RV32I instruction per cycle and decodes it into register-file read/write addresses and a sign-extended immediate, which feed the register file's A1/A2/A3 inputs and the execute stage. It also generates control bits and detects load-use hazards, inserting a one-cycle bubble when needed. A valid/ready handshake is used on both sides.

Parameters:
XLEN, 32, data/instruction/PC width
REG_AW, 5, register address width (32 architectural registers)

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Instr_in  input  XLEN  fetched instruction
Pc_in  input  XLEN  PC of Instr_in
In_valid  input  1  fetch presents an instruction
In_ready  output  1  stage accepts Instr_in this cycle (combinational)
Flush  input  1  branch/jump redirect; discard contents
Out_ready  input  1  execute stage can accept
Out_valid  output  1  registered decoded instruction valid
Out_pc  output  XLEN  PC of decoded instruction
A1  output  REG_AW  rs1 address (0 if unused)
A2  output  REG_AW  rs2 address (0 if unused)
A3  output  REG_AW  rd address (0 if RegWrite=0)
Imm  output  XLEN  sign-extended immediate
Opcode  output  7  instr[6:0]
Funct3  output  3  instr[14:12]
Funct7b5  output  1  instr[30]
RegWrite  output  1  instruction writes rd
MemRead  output  1  load
MemWrite  output  1  store
Illegal  output  1  unrecognised opcode
Hazard  output  1  load-use stall active (combinational)

Behaviour:
- Reset (async, Rst_n=0): all registered outputs 0, including Out_valid. In_ready is permitted to go high immediately after reset is released.
- Opcode classes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - Any other opcode: Illegal=1, RegWrite/MemRead/MemWrite=0, A1=A2=A3=0, Imm=0.
- Register usage:
  - uses_rs1: R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: R, STORE, BRANCH.
  - RegWrite=1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR.
  - RegWrite is forced 0 when rd=0. A3 follows RegWrite.
- Immediate generation:
  - I-type (I-ALU, LOAD, JALR): sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R: 0.
- Hazard = In_valid & Out_valid & MemRead & (A3≠0) & ((A3==rs1 & uses_rs1) | (A3==rs2 & uses_rs2)). rs1/rs2 are decoded combinationally from Instr_in.
- In_ready = ~Flush & ~Hazard & (~Out_valid | Out_ready).
- Register update priority, each cycle:
  1. Flush=1: Out_valid <= 0. The incoming instruction is not accepted.
  2. Out_valid & ~Out_ready: hold all outputs unchanged.
  3. Hazard (with downstream ready): load a bubble (Out_valid <= 0, control bits 0). The next cycle Hazard deasserts and the instruction is accepted. The stall lasts exactly one cycle.
  4. In_valid & In_ready: latch the decoded instruction, Out_valid <= 1.
  5. Otherwise: Out_valid <= 0.
- Latency: one cycle from acceptance to Out_valid.
- Throughput: one instruction per cycle with no hazard.
- Outputs never change while Out_valid=1 and Out_ready=0.
- Reset asserted mid-stall or mid-hold clears everything immediately. No state survives reset.

Test Plan:
- Reset then Instr_in=0x00500093 (addi x1,x0,5), In_valid=1, Out_ready=1 -> next cycle Out_valid=1, A1=0, A3=1, Imm=5, RegWrite=1, A2=0.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) back-to-back:
  - cycle with lw at output -> Hazard=1, In_ready=0.
  - next cycle Out_valid=0 (bubble).
  - following cycle add presented: A1=2, A2=1, A3=3.
- 0x00312423 (sw x3,8(x2)) -> A1=2, A2=3, A3=0, Imm=8, MemWrite=1, RegWrite=0. Then 0xFE208EE3 (beq x1,x2,-4) -> Imm=0xFFFFFFFC, A1=1, A2=2.
- Out_ready=0 for 3 cycles with valid output -> all outputs stable, In_ready=0. Release -> next queued instruction appears one cycle later.
- Flush=1 while Out_valid=1 and In_valid=1 -> next cycle Out_valid=0, In_ready=0 during Flush. Opcode 0x7F -> Illegal=1, all control bits 0.
- Rst_n pulsed low asynchronously mid-hold -> Out_valid and all outputs 0 without waiting for a Clk edge.
